// File: rtl/microwave_timer.sv
// Microwave oven controller: door/cook/pause/ring FSM with countdown timer, power duty-cycling and timed bell.
// Optional child lock (adds `lock` port, masks start/add/load) is enabled by defining MW_CHILD_LOCK_EN.
module microwave_timer #(
  parameter int TIME_W     = 10,
  parameter int PWR_W      = 3,
  parameter int ADD_STEP   = 30,
  parameter int BELL_TICKS = 3
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              door,
  input  logic              start,
  input  logic              cancel,
  input  logic              add,
  input  logic              load,
  input  logic [TIME_W-1:0] time_in,
  input  logic [PWR_W-1:0]  power,
  input  logic              sec_tick,
`ifdef MW_CHILD_LOCK_EN
  input  logic              lock,
`endif
  output logic              heat,
  output logic              light,
  output logic              bell,
  output logic              busy,
  output logic [TIME_W-1:0] remaining
);

  localparam int BW = $clog2(BELL_TICKS + 1);
  localparam logic [TIME_W:0] MAXV = {1'b0, {TIME_W{1'b1}}};
  localparam logic [TIME_W:0] STEP = (TIME_W+1)'(ADD_STEP);
  localparam logic [TIME_W:0] ONE  = (TIME_W+1)'(1);

  typedef enum logic [2:0] {S_IDLE, S_OPEN, S_COOK, S_PAUSE, S_RING} state_t;

  state_t            r_state;
  state_t            w_nxt;
  logic [TIME_W-1:0] r_rem;
  logic [TIME_W-1:0] w_rem;
  logic [PWR_W-1:0]  r_duty;
  logic [BW-1:0]     r_bcnt;
  logic              r_light;
  logic              r_bell;
  logic              r_busy;
  logic              w_lock;
  logic              w_start;
  logic              w_add;
  logic              w_load;
  logic [TIME_W:0]   w_dec;
  logic [TIME_W-1:0] w_add_rem;
  logic [TIME_W-1:0] w_cook_rem;
  logic [TIME_W-1:0] w_quick;

  function automatic logic [TIME_W-1:0] sat(input logic [TIME_W:0] v);
    return (v > MAXV) ? MAXV[TIME_W-1:0] : v[TIME_W-1:0];
  endfunction

`ifdef MW_CHILD_LOCK_EN
  assign w_lock = lock;
`else
  assign w_lock = 1'b0;
`endif

  assign w_start    = start & ~w_lock;
  assign w_add      = add & ~w_lock;
  assign w_load     = load & ~w_lock;
  assign w_dec      = (sec_tick && r_rem != '0) ? {1'b0, r_rem} - ONE : {1'b0, r_rem};
  assign w_cook_rem = sat(w_add ? w_dec + STEP : w_dec);
  assign w_add_rem  = sat({1'b0, r_rem} + STEP);
  assign w_quick    = sat(STEP);

  always_comb begin
    w_nxt = r_state;
    w_rem = r_rem;
    case (r_state)
      S_IDLE: begin
        if (door)             w_nxt = S_OPEN;
        else if (cancel)      w_rem = '0;
        else if (w_load)      w_rem = time_in;
        else if (w_add)       w_rem = w_add_rem;
        else if (w_start) begin
          w_nxt = S_COOK;
          if (r_rem == '0)    w_rem = w_quick;
        end
      end
      S_OPEN: begin
        if (cancel)           w_rem = '0;
        else if (w_load)      w_rem = time_in;
        else if (w_add)       w_rem = w_add_rem;
        if (!door)            w_nxt = S_IDLE;
      end
      S_COOK: begin
        if (cancel) begin
          w_rem = '0;
          w_nxt = door ? S_OPEN : S_IDLE;
        end else if (door) begin
          w_nxt = S_PAUSE;
        end else begin
          w_rem = w_cook_rem;
          // A tick that empties the timer rings on the same edge
          if (sec_tick && w_cook_rem == '0) w_nxt = S_RING;
        end
      end
      S_PAUSE: begin
        if (cancel) begin
          w_rem = '0;
          w_nxt = door ? S_OPEN : S_IDLE;
        end else if (!door && w_start) begin
          w_nxt = S_COOK;
        end
      end
      S_RING: begin
        if (door)                                           w_nxt = S_OPEN;
        else if (sec_tick && r_bcnt == BW'(BELL_TICKS - 1)) w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_duty  <= '0;
      r_bcnt  <= '0;
      r_light <= 1'b0;
      r_bell  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_rem   <= w_rem;
      r_duty  <= (w_nxt == S_COOK && r_state == S_COOK) ? r_duty + 1'b1 : '0;
      if (r_state != S_RING) r_bcnt <= '0;
      else if (sec_tick)     r_bcnt <= r_bcnt + 1'b1;
      r_light <= (w_nxt == S_OPEN) || (w_nxt == S_COOK) || (w_nxt == S_PAUSE);
      r_bell  <= (w_nxt == S_RING);
      r_busy  <= (w_nxt == S_COOK) || (w_nxt == S_PAUSE);
    end
  end

  // Heat follows live power; the state term drops it with asynchronous reset
  assign heat      = (r_state == S_COOK) && ((&power) || (r_duty < power));
  assign light     = r_light;
  assign bell      = r_bell;
  assign busy      = r_busy;
  assign remaining = r_rem;

endmodule

// File: tb/tb_microwave_timer.sv
// Randomized and directed bench for microwave_timer against a cycle-level behavioural model.
module tb_microwave_timer;
  localparam int TIME_W = 10, PWR_W = 3, ADD_STEP = 30, BELL_TICKS = 3;
  localparam int MAXT = (1 << TIME_W) - 1;
  localparam int NP = 1 << PWR_W;
  localparam int M_IDLE = 0, M_OPEN = 1, M_COOK = 2, M_PAUSE = 3, M_RING = 4;

  logic clk = 0, nrst = 0;
  logic door = 0, start = 0, cancel = 0, add = 0, load = 0, sec_tick = 0, lock = 0;
  logic [TIME_W-1:0] time_in = '0;
  logic [PWR_W-1:0]  power = '0;
  wire heat, light, bell, busy;
  wire [TIME_W-1:0] remaining;

  int n_chk = 0, n_err = 0;
  int m_st = M_IDLE, m_rem = 0, m_cc = 0, m_bells = 0;
  int hcnt;
  string ph = "rst";

  microwave_timer #(.TIME_W(TIME_W), .PWR_W(PWR_W), .ADD_STEP(ADD_STEP), .BELL_TICKS(BELL_TICKS)) dut (
    .clk(clk), .nrst(nrst), .door(door), .start(start), .cancel(cancel), .add(add), .load(load),
    .time_in(time_in), .power(power), .sec_tick(sec_tick),
`ifdef MW_CHILD_LOCK_EN
    .lock(lock),
`endif
    .heat(heat), .light(light), .bell(bell), .busy(busy), .remaining(remaining));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > MAXT) ? MAXT : v;
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_rem = 0; m_cc = 0; m_bells = 0;
  endtask

  // Spec rules applied to the inputs present at one clock edge
  task automatic model_edge();
    int ost, r;
    bit s, a, l;
    s = start && !lock; a = add && !lock; l = load && !lock;
    ost = m_st;
    case (m_st)
      M_IDLE: begin
        if (door) m_st = M_OPEN;
        else if (cancel) m_rem = 0;
        else if (l) m_rem = int'(time_in);
        else if (a) m_rem = sat(m_rem + ADD_STEP);
        else if (s) begin
          if (m_rem == 0) m_rem = ADD_STEP;
          m_st = M_COOK;
        end
      end
      M_OPEN: begin
        if (cancel) m_rem = 0;
        else if (l) m_rem = int'(time_in);
        else if (a) m_rem = sat(m_rem + ADD_STEP);
        m_st = door ? M_OPEN : M_IDLE;
      end
      M_COOK: begin
        if (cancel) begin m_rem = 0; m_st = door ? M_OPEN : M_IDLE; end
        else if (door) m_st = M_PAUSE;
        else begin
          r = m_rem;
          if (sec_tick && r > 0) r = r - 1;
          if (a) r = sat(r + ADD_STEP);
          if (sec_tick && r == 0) m_st = M_RING;
          m_rem = r;
        end
      end
      M_PAUSE: begin
        if (cancel) begin m_rem = 0; m_st = door ? M_OPEN : M_IDLE; end
        else if (!door && s) m_st = M_COOK;
      end
      default: begin
        if (door) m_st = M_OPEN;
        else if (sec_tick) begin
          m_bells++;
          if (m_bells == BELL_TICKS) m_st = M_IDLE;
        end
      end
    endcase
    if (m_st == M_COOK && ost == M_COOK) m_cc++; else m_cc = 0;
    if (m_st == M_RING && ost != M_RING) m_bells = 0;
  endtask

  task automatic check_outs();
    chk({ph, ".light"}, light, (m_st == M_OPEN || m_st == M_COOK || m_st == M_PAUSE));
    chk({ph, ".bell"}, bell, (m_st == M_RING));
    chk({ph, ".busy"}, busy, (m_st == M_COOK || m_st == M_PAUSE));
    chk({ph, ".heat"}, heat, (m_st == M_COOK && (int'(power) == NP - 1 || (m_cc % NP) < int'(power))));
    chk({ph, ".rem"}, remaining, m_rem);
  endtask

  task automatic step();
    @(posedge clk);
    if (nrst) model_edge(); else model_reset();
    #1;
    check_outs();
    start = 0; cancel = 0; add = 0; load = 0; sec_tick = 0;
  endtask

  task automatic tick_after(input int n);
    repeat (n) step();
    sec_tick = 1;
    step();
  endtask

  initial begin
    #1;
    chk("rst.heat", heat, 0); chk("rst.light", light, 0); chk("rst.bell", bell, 0);
    chk("rst.busy", busy, 0); chk("rst.rem", remaining, 0);
    step(); step();
    nrst = 1;
    step();

    ph = "basic"; power = '1; time_in = 3;
    load = 1; step();
    start = 1; step();
    chk("basic.cook_heat", heat, 1);
    tick_after(2); chk("basic.rem2", remaining, 2);
    tick_after(2); chk("basic.rem1", remaining, 1);
    tick_after(2); chk("basic.rem0", remaining, 0); chk("basic.ring", bell, 1);
    tick_after(1); tick_after(1); chk("basic.bell_held", bell, 1);
    tick_after(1); chk("basic.bell_off", bell, 0); chk("basic.idle_light", light, 0);

    ph = "duty"; power = 2; time_in = 100;
    load = 1; step(); start = 1; step();
    hcnt = 0;
    for (int i = 0; i < 16; i++) begin step(); hcnt += int'(heat); end
    chk("duty.pwr2_of16", hcnt, 4);
    power = 0; hcnt = 0;
    for (int i = 0; i < 8; i++) begin step(); hcnt += int'(heat); end
    chk("duty.pwr0", hcnt, 0); chk("duty.pwr0_light", light, 1);
    cancel = 1; step();

    ph = "pause"; power = '1; time_in = 5;
    load = 1; step(); start = 1; step();
    tick_after(1); tick_after(1);
    door = 1; step();
    chk("pause.busy", busy, 1); chk("pause.heat", heat, 0); chk("pause.rem", remaining, 3);
    for (int i = 0; i < 4; i++) begin sec_tick = 1; step(); end
    chk("pause.frozen", remaining, 3);
    door = 0; start = 1; step();
    chk("pause.resume_heat", heat, 1); chk("pause.resume_rem", remaining, 3);
    cancel = 1; door = 1; step();
    chk("pause.cxl_light", light, 1); chk("pause.cxl_busy", busy, 0); chk("pause.cxl_rem", remaining, 0);
    door = 0; step();

    ph = "quick";
    start = 1; step(); chk("quick.rem30", remaining, 30);
    add = 1; step(); add = 1; step(); chk("quick.rem90", remaining, 90);
    cancel = 1; step();
    time_in = 1020; load = 1; step();
    add = 1; step(); chk("quick.sat", remaining, 1023);
    add = 1; step(); chk("quick.sat2", remaining, 1023);

    ph = "ringdoor"; time_in = 1;
    load = 1; step(); start = 1; step();
    sec_tick = 1; step(); chk("ringdoor.bell", bell, 1);
    door = 1; step(); chk("ringdoor.silent", bell, 0); chk("ringdoor.light", light, 1);
    door = 0; step();

`ifdef MW_CHILD_LOCK_EN
    ph = "lock"; lock = 1; time_in = 50;
    load = 1; step(); chk("lock.load", remaining, 0);
    add = 1; step(); chk("lock.add", remaining, 0);
    start = 1; step(); chk("lock.start", busy, 0);
    lock = 0; load = 1; step();
    lock = 1; cancel = 1; step(); chk("lock.cancel", remaining, 0);
    lock = 0; start = 1; step(); chk("lock.start_ok", busy, 1); chk("lock.quick", remaining, 30);
    cancel = 1; step();
`endif

    ph = "rand";
    for (int i = 0; i < 3000; i++) begin
      sec_tick = ($urandom % 4) == 0;
      start    = ($urandom % 6) == 0;
      add      = ($urandom % 20) == 0;
      load     = ($urandom % 15) == 0;
      cancel   = ($urandom % 40) == 0;
      if (($urandom % 25) == 0) door = ~door;
      if (($urandom % 50) == 0) power = PWR_W'($urandom);
      time_in = (($urandom % 8) == 0) ? TIME_W'($urandom) : TIME_W'($urandom % 40);
`ifdef MW_CHILD_LOCK_EN
      if (($urandom % 30) == 0) lock = ~lock;
`endif
      step();
    end

    ph = "arst"; door = 0; lock = 0; power = '1; time_in = 10;
    step(); cancel = 1; step();
    load = 1; step(); start = 1; step(); step();
    #2 nrst = 0;
    #1;
    chk("arst.heat", heat, 0); chk("arst.rem", remaining, 0); chk("arst.light", light, 0);
    model_reset();
    @(posedge clk); #1 nrst = 1;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
